pc_step_controller: RTL and testbench

Front-panel sequencer for the program counter. Takes three raw active-low pushbuttons (clear, step, run/stop) and debounces each into a single-cycle press-and-release event. Drives the PC through single-step or free-run modes. Every PC update is presented to the fetch datapath over a req/ack handshake.

---
 rtl/pc_step_controller_pkg.sv | 22 ++
 rtl/pc_step_controller_debounce.sv | 70 +++++++
 rtl/pc_step_controller.sv | 147 ++++++++++++++
 tb/tb_pc_step_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_step_controller_pkg.sv
// Shared types and defaults for the program-counter front-panel sequencer.
// The state enum is also used by the bench to read the debug state output.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_WAIT = 2'd1,
        REQ      = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam int DEF_PC_WIDTH        = 8;
    localparam int DEF_PC_MAX          = 255;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_RUN_DIV         = 5000000;

    // Counter width able to hold the value 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pc_step_controller_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, then a press phase and
// a release phase that must each be stable for DEBOUNCE_CYCLES, then a 1-cycle pulse.
module button_debounce
    import pc_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse,
    output logic armed
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          armed_q, armed_nxt;
    logic          pulse_q, pulse_nxt;

    // Synchronizer resets to the released level so reset exit creates no press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            cnt     <= '0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            cnt     <= cnt_nxt;
            armed_q <= armed_nxt;
            pulse_q <= pulse_nxt;
        end
    end

    assign level = sync[1];

    always_comb begin
        cnt_nxt   = cnt;
        armed_nxt = armed_q;
        pulse_nxt = 1'b0;
        if (!armed_q) begin
            if (level) begin
                cnt_nxt = '0;
            end else if (cnt == LAST) begin
                armed_nxt = 1'b1;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            if (!level) begin
                cnt_nxt = '0;
            end else if (cnt == LAST) begin
                pulse_nxt = 1'b1;
                armed_nxt = 1'b0;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign pulse = pulse_q;
    assign armed = armed_q;

endmodule

// File: rtl/pc_step_controller.sv
// Front-panel PC sequencer: debounced clear/step/run buttons drive single-step
// or free-run PC updates, each offered to the fetch datapath over req/ack.
module pc_step_controller
    import pc_ctrl_pkg::*;
#(
    parameter int PC_WIDTH        = DEF_PC_WIDTH,
    parameter int PC_MAX          = DEF_PC_MAX,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_btn_clr,
    input  logic                i_btn_step,
    input  logic                i_btn_run,
    input  logic                i_fetch_ack,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_fetch_req,
    output logic                o_running,
    output logic                o_halted,
    output state_t              o_state,
    output logic [2:0]          o_btn_armed
);

    // Handshake: o_fetch_req rises with a new o_pc and both hold until i_fetch_ack
    // is sampled high on a rising edge; req drops on that same edge. Ack is
    // ignored whenever no request is outstanding.

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [PC_WIDTH-1:0] PC_LAST  = PC_WIDTH'(PC_MAX);

    logic clr_ev, step_ev, run_ev;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(i_clk), .rst_n(i_reset), .btn(i_btn_clr),  .pulse(clr_ev),  .armed(o_btn_armed[0])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(i_clk), .rst_n(i_reset), .btn(i_btn_step), .pulse(step_ev), .armed(o_btn_armed[1])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(i_clk), .rst_n(i_reset), .btn(i_btn_run),  .pulse(run_ev),  .armed(o_btn_armed[2])
    );

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic                req, req_nxt;
    logic                running, running_nxt, run_tog;
    logic                halted, halted_nxt;
    logic [DIV_W-1:0]    div, div_nxt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            pc      <= '0;
            req     <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
            div     <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            req     <= req_nxt;
            running <= running_nxt;
            halted  <= halted_nxt;
            div     <= div_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        req_nxt     = req;
        running_nxt = running;
        halted_nxt  = halted;
        div_nxt     = div;
        run_tog     = running ^ run_ev;
        if (clr_ev) begin
            state_nxt   = IDLE;
            pc_nxt      = '0;
            req_nxt     = 1'b0;
            running_nxt = 1'b0;
            halted_nxt  = 1'b0;
            div_nxt     = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run_ev) begin
                        running_nxt = 1'b1;
                        div_nxt     = '0;
                        state_nxt   = RUN_WAIT;
                    end else if (step_ev) begin
                        if (pc == PC_LAST) begin
                            halted_nxt = 1'b1;
                            state_nxt  = HALT;
                        end else begin
                            pc_nxt    = pc + 1'b1;
                            req_nxt   = 1'b1;
                            state_nxt = REQ;
                        end
                    end
                end
                RUN_WAIT: begin
                    if (run_ev) begin
                        running_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end else if (div == DIV_LAST) begin
                        div_nxt = '0;
                        if (pc == PC_LAST) begin
                            halted_nxt  = 1'b1;
                            running_nxt = 1'b0;
                            state_nxt   = HALT;
                        end else begin
                            pc_nxt    = pc + 1'b1;
                            req_nxt   = 1'b1;
                            state_nxt = REQ;
                        end
                    end else begin
                        div_nxt = div + 1'b1;
                    end
                end
                REQ: begin
                    // A run toggle here decides where the ack returns to.
                    running_nxt = run_tog;
                    if (i_fetch_ack) begin
                        req_nxt   = 1'b0;
                        div_nxt   = '0;
                        state_nxt = run_tog ? RUN_WAIT : IDLE;
                    end
                end
                HALT: begin
                    halted_nxt  = 1'b1;
                    running_nxt = 1'b0;
                    req_nxt     = 1'b0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign o_pc        = pc;
    assign o_fetch_req = req;
    assign o_running   = running;
    assign o_halted    = halted;
    assign o_state     = state;

endmodule

// File: tb/tb_pc_step_controller.sv
// Bench for pc_step_controller: vector table, directed multi-cycle sequences and
// a randomized run against a run-length/countdown reference model.
module tb_pc_step_controller;
    import pc_ctrl_pkg::*;

    localparam int PW   = 8;
    localparam int PMAX = 5;
    localparam int DB   = 4;
    localparam int RD   = 8;
    localparam logic [2:0] M_CLR  = 3'b001;
    localparam logic [2:0] M_STEP = 3'b010;
    localparam logic [2:0] M_RUN  = 3'b100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          b_clr = 1'b1, b_step = 1'b1, b_run = 1'b1, ack = 1'b0;
    logic [PW-1:0] pc;
    logic          req, running, halted;
    state_t        st;
    logic [2:0]    armed;

    pc_step_controller #(.PC_WIDTH(PW), .PC_MAX(PMAX), .DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_btn_clr(b_clr), .i_btn_step(b_step),
        .i_btn_run(b_run), .i_fetch_ack(ack), .o_pc(pc), .o_fetch_req(req),
        .o_running(running), .o_halted(halted), .o_state(st), .o_btn_armed(armed)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic press(input logic [2:0] mask, input int low_n, input int high_n);
        b_clr  = ~mask[0];
        b_step = ~mask[1];
        b_run  = ~mask[2];
        repeat (low_n) @(negedge clk);
        b_clr = 1'b1; b_step = 1'b1; b_run = 1'b1;
        repeat (high_n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_pc(input int v, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(pc) == v) break;
            @(negedge clk);
        end
        check("wait_pc", int'(pc), v);
    endtask

    task automatic check_outs(input string tag, input int e_pc, input int e_req,
                              input int e_run, input int e_halt, input state_t e_st);
        check({tag, "_pc"}, int'(pc), e_pc);
        check({tag, "_req"}, int'(req), e_req);
        check({tag, "_running"}, int'(running), e_run);
        check({tag, "_halted"}, int'(halted), e_halt);
        check({tag, "_state"}, int'(st), int'(e_st));
    endtask

    // Reference model: button events from run lengths of the synchronized level,
    // controller from a countdown of cycles remaining in the run interval.
    int     m_pc, m_ticks;
    bit     m_req, m_run, m_halt;
    state_t m_st;
    bit     m_p1[3], m_p2[3], m_arm[3], m_ev[3];
    int     m_low[3], m_high[3];

    task automatic model_reset();
        m_pc = 0; m_ticks = 0; m_req = 0; m_run = 0; m_halt = 0; m_st = IDLE;
        for (int b = 0; b < 3; b++) begin
            m_p1[b] = 1; m_p2[b] = 1; m_arm[b] = 0; m_ev[b] = 0; m_low[b] = 0; m_high[b] = 0;
        end
    endtask

    task automatic model_advance();
        if (m_pc == PMAX) begin
            m_st = HALT; m_halt = 1; m_run = 0; m_req = 0;
        end else begin
            m_pc++; m_req = 1; m_st = REQ;
        end
    endtask

    task automatic model_step(input logic [2:0] raw, input logic a);
        bit ce, se, re;
        ce = m_ev[0]; se = m_ev[1]; re = m_ev[2];
        if (ce) begin
            m_pc = 0; m_req = 0; m_run = 0; m_halt = 0; m_st = IDLE;
        end else begin
            case (m_st)
                IDLE:
                    if (re) begin m_run = 1; m_ticks = RD; m_st = RUN_WAIT; end
                    else if (se) model_advance();
                RUN_WAIT:
                    if (re) begin m_run = 0; m_st = IDLE; end
                    else if (m_ticks == 1) model_advance();
                    else m_ticks--;
                REQ: begin
                    if (re) m_run = !m_run;
                    if (a) begin
                        m_req = 0;
                        m_ticks = RD;
                        m_st = m_run ? RUN_WAIT : IDLE;
                    end
                end
                default: ;
            endcase
        end
        for (int b = 0; b < 3; b++) begin
            m_ev[b] = 0;
            if (!m_p2[b]) begin
                m_low[b]++; m_high[b] = 0;
                if (!m_arm[b] && m_low[b] >= DB) m_arm[b] = 1;
            end else begin
                m_high[b]++; m_low[b] = 0;
                if (m_arm[b] && m_high[b] >= DB) begin m_ev[b] = 1; m_arm[b] = 0; end
            end
            m_p2[b] = m_p1[b];
            m_p1[b] = raw[b];
        end
    endtask

    typedef struct {
        logic [2:0] mask;
        bit         do_ack;
        int         pc;
        int         req;
        int         run;
        int         halt;
        state_t     st;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int last, cyc, prev;
        int seg[3];
        logic lvl[3];
        logic [12:0] act, exp;

        tbl[0]  = '{M_STEP,         1'b0, 1, 1, 0, 0, REQ};
        tbl[1]  = '{M_STEP,         1'b1, 1, 0, 0, 0, IDLE};
        tbl[2]  = '{M_STEP,         1'b1, 2, 0, 0, 0, IDLE};
        tbl[3]  = '{M_STEP,         1'b1, 3, 0, 0, 0, IDLE};
        tbl[4]  = '{M_CLR | M_STEP, 1'b0, 0, 0, 0, 0, IDLE};
        tbl[5]  = '{M_STEP,         1'b1, 1, 0, 0, 0, IDLE};
        tbl[6]  = '{M_STEP,         1'b1, 2, 0, 0, 0, IDLE};
        tbl[7]  = '{M_STEP,         1'b1, 3, 0, 0, 0, IDLE};
        tbl[8]  = '{M_STEP,         1'b1, 4, 0, 0, 0, IDLE};
        tbl[9]  = '{M_STEP,         1'b1, 5, 0, 0, 0, IDLE};
        tbl[10] = '{M_STEP,         1'b0, 5, 0, 0, 1, HALT};
        tbl[11] = '{M_RUN,          1'b0, 5, 0, 0, 1, HALT};
        tbl[12] = '{M_STEP,         1'b0, 5, 0, 0, 1, HALT};
        tbl[13] = '{M_CLR,          1'b0, 0, 0, 0, 0, IDLE};

        // Reset state
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_armed", int'(armed), 0);

        // Presses too short or broken by a glitch never produce an event
        press(M_STEP, 3, 10);
        check("short_press_pc", int'(pc), 0);
        check("short_press_armed", int'(armed), 0);
        b_step = 1'b0; repeat (2) @(negedge clk);
        b_step = 1'b1; @(negedge clk);
        b_step = 1'b0; repeat (3) @(negedge clk);
        b_step = 1'b1; repeat (10) @(negedge clk);
        check("glitch_pc", int'(pc), 0);
        check("glitch_req", int'(req), 0);

        // Vector table: each row is a clean press, optional ack, then outputs
        for (int i = 0; i < 14; i++) begin
            press(tbl[i].mask, 6, 6);
            repeat (3) @(negedge clk);
            if (tbl[i].do_ack) ack_pulse();
            check_outs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].req, tbl[i].run,
                       tbl[i].halt, tbl[i].st);
        end

        // Free run with ack held high: 9-cycle spacing, then halt at PC_MAX
        ack = 1'b1;
        press(M_RUN, 6, 6);
        last = -1; cyc = 0; prev = int'(pc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (halted) begin
                check("halt_spacing", cyc - last, 9);
                break;
            end
            if (int'(pc) != prev) begin
                check("run_pc", int'(pc), prev + 1);
                if (last >= 0) check("run_spacing", cyc - last, 9);
                last = cyc; prev = int'(pc);
            end
        end
        check_outs("run_halt", 5, 0, 0, 1, HALT);
        ack = 1'b0;
        press(M_STEP, 6, 6);
        press(M_RUN, 6, 6);
        repeat (3) @(negedge clk);
        check_outs("halt_ignores", 5, 0, 0, 1, HALT);

        // Run/stop while a request is outstanding and ack is withheld
        press(M_CLR, 6, 6);
        repeat (2) @(negedge clk);
        press(M_RUN, 6, 6);
        for (int i = 0; i < 40; i++) begin
            if (req) break;
            @(negedge clk);
        end
        check("req_seen", int'(req), 1);
        check("req_pc", int'(pc), 1);
        press(M_RUN, 6, 6);
        repeat (20) @(negedge clk);
        check("frozen_pc", int'(pc), 1);
        check("frozen_req", int'(req), 1);
        ack_pulse();
        check_outs("stop_after_ack", 1, 0, 0, 0, IDLE);
        repeat (30) @(negedge clk);
        check("no_more_incr", int'(pc), 1);

        // Clear during REQ aborts the request on the next edge without ack
        press(M_STEP, 6, 6);
        repeat (2) @(negedge clk);
        check("pre_clr_req", int'(req), 1);
        press(M_CLR, 6, 6);
        check("clr_edge_req_still", int'(req), 1);
        @(negedge clk);
        check_outs("clr_in_req", 0, 0, 0, 0, IDLE);

        // Asynchronous reset mid-run
        ack = 1'b1;
        press(M_RUN, 6, 6);
        wait_pc(4, 100);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b0;
        press(M_STEP, 6, 6);
        repeat (3) @(negedge clk);
        check_outs("post_reset_step", 1, 1, 0, 0, REQ);
        ack_pulse();

        // Randomized buttons and ack against the reference model
        rst_n = 1'b0;
        b_clr = 1'b1; b_step = 1'b1; b_run = 1'b1; ack = 1'b0;
        model_reset();
        for (int b = 0; b < 3; b++) begin seg[b] = 0; lvl[b] = 1'b1; end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            model_step({b_run, b_step, b_clr}, ack);
            @(negedge clk);
            act = {pc, req, running, halted, st};
            exp = {PW'(m_pc), m_req, m_run, m_halt, m_st};
            check($sformatf("random_cyc%0d", n), int'(act), int'(exp));
            for (int b = 0; b < 3; b++) begin
                if (seg[b] == 0) begin
                    seg[b] = $urandom_range(1, 8);
                    lvl[b] = (b == 0) ? ($urandom_range(0, 5) != 0) : 1'($urandom_range(0, 1));
                end
                seg[b]--;
            end
            b_clr  = lvl[0];
            b_step = lvl[1];
            b_run  = lvl[2];
            ack    = ($urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
